// File: rtl/soc_system_sysid_checker.sv
// soc_system_sysid_checker
// Avalon-MM master that reads the system-ID slave (address 0 = ID, address 1 =
// build timestamp) and compares both words against expected constants. The
// latched values and the match/timeout flags are published so that FPGA-side
// logic can stay gated until the loaded image is confirmed.
//
// Optional feature: define SYSID_CHECK_PERIODIC_EN to add a free-running
// recheck timer and the sticky 'changed' flag. Without it, 'changed' is 0.
//
// Handshake: a read is issued by holding sysid_read=1 with a stable
// sysid_address. It is accepted in the cycle where sysid_read=1 and
// sysid_waitrequest=0. The data is then sampled READ_LATENCY cycles later
// (in the acceptance cycle itself when READ_LATENCY=0).
module soc_system_sysid_checker #(
    parameter logic [31:0] EXPECTED_ID    = 32'hACD51302,
    parameter logic [31:0] EXPECTED_TS    = 32'h59103431,
    parameter int          READ_LATENCY   = 1,
    parameter int          TIMEOUT_CYCLES = 1023,
    parameter bit          AUTO_START     = 1'b1,
    parameter int          RECHECK_CYCLES = 50000000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        sysid_address,
    output logic        sysid_read,
    input  logic        sysid_waitrequest,
    input  logic [31:0] sysid_readdata,
    output logic [31:0] id_value,
    output logic [31:0] ts_value,
    output logic        busy,
    output logic        done,
    output logic        id_match,
    output logic        ts_match,
    output logic        timeout_err,
    output logic        changed,
    output logic [2:0]  state_dbg
);

    localparam int             SW      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [SW-1:0]  TO_LAST = SW'(TIMEOUT_CYCLES - 1);
    localparam logic [1:0]     RL      = 2'(READ_LATENCY);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RD_ID  = 3'd1,
        S_LAT_ID = 3'd2,
        S_RD_TS  = 3'd3,
        S_LAT_TS = 3'd4,
        S_DONE   = 3'd5,
        S_ERR    = 3'd6
    } state_t;

    state_t        state;
    logic [SW-1:0] stall_cnt;
    logic [1:0]    lat_cnt;
    logic          auto_pend;
    logic          start_req;
    logic          check_begin;
    logic          in_rd;
    logic          accepted;
    logic          lat_hit;
    logic          id_cap;
    logic          ts_cap;
    logic          stall_to;

    assign state_dbg = state;

    // Event decode shared by the FSM and the optional recheck logic.
    always_comb begin
        in_rd       = (state == S_RD_ID) || (state == S_RD_TS);
        accepted    = in_rd && sysid_read && !sysid_waitrequest;
        lat_hit     = (lat_cnt == RL);
        check_begin = (state == S_IDLE) && start_req;
        id_cap      = ((state == S_RD_ID) && accepted && (READ_LATENCY == 0)) ||
                      ((state == S_LAT_ID) && lat_hit);
        ts_cap      = ((state == S_RD_TS) && accepted && (READ_LATENCY == 0)) ||
                      ((state == S_LAT_TS) && lat_hit);
        stall_to    = in_rd && sysid_waitrequest && (stall_cnt == TO_LAST);
    end

    // Check sequencer: two reads, optional latency wait, then DONE or ERR.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state         <= S_IDLE;
            stall_cnt     <= '0;
            lat_cnt       <= '0;
            auto_pend     <= AUTO_START;
            sysid_address <= 1'b0;
            sysid_read    <= 1'b0;
            id_value      <= '0;
            ts_value      <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            id_match      <= 1'b0;
            ts_match      <= 1'b0;
            timeout_err   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (check_begin) begin
                        done          <= 1'b0;
                        id_match      <= 1'b0;
                        ts_match      <= 1'b0;
                        timeout_err   <= 1'b0;
                        busy          <= 1'b1;
                        sysid_read    <= 1'b1;
                        sysid_address <= 1'b0;
                        stall_cnt     <= '0;
                        auto_pend     <= 1'b0;
                        state         <= S_RD_ID;
                    end
                end
                S_RD_ID, S_RD_TS: begin
                    if (accepted) begin
                        stall_cnt <= '0;
                        if (id_cap) begin
                            // Zero latency: go straight into the TS read.
                            id_value      <= sysid_readdata;
                            sysid_address <= 1'b1;
                            state         <= S_RD_TS;
                        end else if (ts_cap) begin
                            ts_value   <= sysid_readdata;
                            id_match   <= (id_value == EXPECTED_ID);
                            ts_match   <= (sysid_readdata == EXPECTED_TS);
                            done       <= 1'b1;
                            busy       <= 1'b0;
                            sysid_read <= 1'b0;
                            state      <= S_DONE;
                        end else begin
                            sysid_read <= 1'b0;
                            lat_cnt    <= 2'd1;
                            state      <= (state == S_RD_ID) ? S_LAT_ID : S_LAT_TS;
                        end
                    end else if (stall_to) begin
                        sysid_read  <= 1'b0;
                        timeout_err <= 1'b1;
                        done        <= 1'b1;
                        busy        <= 1'b0;
                        id_match    <= 1'b0;
                        ts_match    <= 1'b0;
                        state       <= S_ERR;
                    end else if (sysid_waitrequest) begin
                        // Bounded by the timeout compare above, so it never wraps.
                        stall_cnt <= stall_cnt + 1'b1;
                    end
                end
                S_LAT_ID: begin
                    if (id_cap) begin
                        id_value      <= sysid_readdata;
                        sysid_read    <= 1'b1;
                        sysid_address <= 1'b1;
                        stall_cnt     <= '0;
                        state         <= S_RD_TS;
                    end else begin
                        lat_cnt <= lat_cnt + 2'd1;
                    end
                end
                S_LAT_TS: begin
                    if (ts_cap) begin
                        ts_value <= sysid_readdata;
                        id_match <= (id_value == EXPECTED_ID);
                        ts_match <= (sysid_readdata == EXPECTED_TS);
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        state    <= S_DONE;
                    end else begin
                        lat_cnt <= lat_cnt + 2'd1;
                    end
                end
                S_DONE, S_ERR: begin
                    // One settling cycle; a start seen here is not latched.
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef SYSID_CHECK_PERIODIC_EN
    localparam int            RW       = (RECHECK_CYCLES > 1) ? $clog2(RECHECK_CYCLES) : 1;
    localparam logic [RW-1:0] RC_LAST  = RW'(RECHECK_CYCLES - 1);

    logic [RW-1:0] recheck_cnt;
    logic          recheck_due;
    logic          is_recheck;
    logic [31:0]   id_prev;
    logic [31:0]   ts_prev;

    assign start_req = start || auto_pend || recheck_due;

    // Recheck timer, deferred request, and comparison against the prior check.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            recheck_cnt <= '0;
            recheck_due <= 1'b0;
            is_recheck  <= 1'b0;
            id_prev     <= '0;
            ts_prev     <= '0;
            changed     <= 1'b0;
        end else begin
            if (check_begin) begin
                recheck_due <= 1'b0;
                is_recheck  <= recheck_due;
                id_prev     <= id_value;
                ts_prev     <= ts_value;
            end
            if (recheck_cnt == RC_LAST) begin
                recheck_cnt <= '0;
                recheck_due <= 1'b1;
            end else begin
                recheck_cnt <= recheck_cnt + 1'b1;
            end
            // A timed-out recheck never reaches ts_cap, so it cannot set this.
            if (ts_cap && is_recheck &&
                ((id_value != id_prev) || (sysid_readdata != ts_prev))) begin
                changed <= 1'b1;
            end
        end
    end
`else
    logic unused_recheck;

    assign start_req      = start || auto_pend;
    assign changed        = 1'b0;
    assign unused_recheck = (RECHECK_CYCLES != 0);
`endif

endmodule
